// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM controller port between two requesters: port 0
//   (instruction fetch) and port 1 (data memory stage). Round-robin grant,
//   one access at a time, a one-cycle RECOVER gap after every access so the
//   controller's access counter reloads, and a watchdog that aborts accesses
//   whose ready never arrives.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rd0/wr0/addr0/wdata0       port 0 request (level, held until done0)
//   rdata0, done0              port 0 registered read data, completion pulse
//   rd1/wr1/addr1/wdata1       port 1 request
//   rdata1, done1              port 1 read data, completion pulse
//   err                        sticky watchdog-abort flag
//   sram_rd_en, sram_wr_en     controller enables (combinational from state)
//   sram_address, sram_writeData  controller address / write data
//   sram_readData, sram_ready  controller read data / ready
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TMO_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              err,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_writeData,
  input  logic [DATA_W-1:0] sram_readData,
  input  logic              sram_ready
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, RECOVER} state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic [TMO_W-1:0]  wdog_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              done0_q, done1_q;
  logic              err_q;

  logic req0, req1, pick1, wdog_hit;

  assign req0     = rd0 | wr0;
  assign req1     = rd1 | wr1;
  // On a tie the port that was not granted last wins.
  assign pick1    = req1 & (~req0 | ~last_grant_q);
  assign wdog_hit = (wdog_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            state_q      <= pick1 ? GNT1 : GNT0;
            last_grant_q <= pick1;
            wdog_q       <= '0;
          end
        end
        GNT0, GNT1: begin
          // Ready has priority over the watchdog in the same cycle.
          if (sram_ready || wdog_hit) begin
            state_q <= RECOVER;
            if (state_q == GNT0) done0_q <= 1'b1;
            else                 done1_q <= 1'b1;
            if (sram_ready) begin
              if (state_q == GNT0 && rd0 && !wr0) rdata0_q <= sram_readData;
              if (state_q == GNT1 && rd1 && !wr1) rdata1_q <= sram_readData;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + TMO_W'(1);
          end
        end
        RECOVER: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sram_rd_en     = 1'b0;
    sram_wr_en     = 1'b0;
    sram_address   = '0;
    sram_writeData = '0;
    unique case (state_q)
      GNT0: begin
        sram_address   = addr0;
        sram_writeData = wdata0;
        sram_wr_en     = wr0;
        sram_rd_en     = rd0 & ~wr0;
      end
      GNT1: begin
        sram_address   = addr1;
        sram_writeData = wdata1;
        sram_wr_en     = wr1;
        sram_rd_en     = rd1 & ~wr1;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;
  localparam int          NACC = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd0, wr0, rd1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic          done0, done1, err;
  logic          sram_rd_en, sram_wr_en, sram_ready;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_writeData, sram_readData;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TMO_W(5)) dut (
    .clk(clk), .rst(rst),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .done0(done0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .done1(done1),
    .err(err), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_writeData(sram_writeData),
    .sram_readData(sram_readData), .sram_ready(sram_ready)
  );

  // Controller model: ready in the ctl_lat-th enabled cycle, read data is a
  // hash of the address unless forced.
  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int unsigned ctl_lat = 3;
  int unsigned ctl_cnt = 0;
  bit          ctl_hang = 1'b0;
  bit          ctl_force = 1'b0;
  logic [31:0] ctl_rdata = 32'h0;

  always @(posedge clk) begin
    if (sram_rd_en || sram_wr_en) ctl_cnt <= ctl_cnt + 1;
    else                          ctl_cnt <= 0;
  end
  assign sram_ready    = !ctl_hang && (sram_rd_en || sram_wr_en) && (ctl_cnt == ctl_lat - 1);
  assign sram_readData = ctl_force ? ctl_rdata : rdfn(sram_address);

  // Bus monitor: one record per grant (enable burst), done pulse counters.
  logic [31:0] acc_addr [NACC];
  logic [31:0] acc_wdata[NACC];
  bit          acc_wr   [NACC];
  int          acc_len  [NACC];
  int          acc_gap  [NACC];
  bit          acc_bad  [NACC];
  int n_acc = 0, idle_cnt = 0, n_done0 = 0, n_done1 = 0, n_wide = 0, n_both = 0;
  bit prev_en = 1'b0, prev_d0 = 1'b0, prev_d1 = 1'b0;

  always @(negedge clk) begin
    if (sram_rd_en && sram_wr_en) n_both <= n_both + 1;
    if ((sram_rd_en || sram_wr_en) && !prev_en && n_acc < NACC) begin
      acc_addr[n_acc]  <= sram_address;
      acc_wdata[n_acc] <= sram_writeData;
      acc_wr[n_acc]    <= sram_wr_en;
      acc_len[n_acc]   <= 1;
      acc_gap[n_acc]   <= idle_cnt;
      acc_bad[n_acc]   <= 1'b0;
      n_acc            <= n_acc + 1;
    end else if ((sram_rd_en || sram_wr_en) && n_acc > 0) begin
      acc_len[n_acc-1] <= acc_len[n_acc-1] + 1;
      if (sram_address !== acc_addr[n_acc-1] || sram_wr_en !== acc_wr[n_acc-1])
        acc_bad[n_acc-1] <= 1'b1;
    end
    idle_cnt <= (sram_rd_en || sram_wr_en) ? 0 : idle_cnt + 1;
    if (done0 && !prev_d0) n_done0 <= n_done0 + 1;
    if (done1 && !prev_d1) n_done1 <= n_done1 + 1;
    if ((done0 && prev_d0) || (done1 && prev_d1)) n_wide <= n_wide + 1;
    prev_en <= sram_rd_en || sram_wr_en;
    prev_d0 <= done0;
    prev_d1 <= done1;
  end

  // Requester operation lists
  bit          op_rd   [2][8];
  bit          op_wr   [2][8];
  logic [31:0] op_addr [2][8];
  logic [31:0] op_wdata[2][8];
  int          op_n    [2];

  // Reference model state
  int          mdl_last;
  logic [31:0] mdl_rd[2];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic agent(input int p);
    int t;
    for (int i = 0; i < op_n[p]; i++) begin
      if (p == 0) begin
        rd0 = op_rd[0][i]; wr0 = op_wr[0][i]; addr0 = op_addr[0][i]; wdata0 = op_wdata[0][i];
      end else begin
        rd1 = op_rd[1][i]; wr1 = op_wr[1][i]; addr1 = op_addr[1][i]; wdata1 = op_wdata[1][i];
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (((p == 0) ? done0 : done1) !== 1'b1 && t < 100);
      checks++;
      if (t >= 100) begin
        errors++;
        $display("FAIL agent%0d_done: op %0d got no done after %0d cycles, want done", p, i, t);
      end
    end
    if (p == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else        begin rd1 = 1'b0; wr1 = 1'b0; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    checks++; if ({done0, done1, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {done0, done1, err}); end
    checks++; if ({sram_rd_en, sram_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {sram_rd_en, sram_wr_en}); end
    checks++; if (sram_address !== 32'h0 || sram_writeData !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", sram_address, sram_writeData); end
  endtask

  task automatic test_read();
    int t, base, d0, d1, w;
    ctl_lat = 3; ctl_force = 1'b1; ctl_rdata = 32'hDEADBEEF;
    base = n_acc; d0 = n_done0; d1 = n_done1; w = n_wide;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h400; wdata0 = 32'h0;
    t = 0;
    do begin tick(1); t++; end while (done0 !== 1'b1 && t < 50);
    checks++; if (t != 4) begin errors++; $display("FAIL read_latency: got %0d want 4", t); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata0: got %h want deadbeef", rdata0); end
    rd0 = 1'b0;
    tick(4);
    checks++; if (n_acc != base + 1) begin errors++; $display("FAIL read_grants: got %0d want %0d", n_acc - base, 1); end
    checks++; if (acc_len[base] != 3) begin errors++; $display("FAIL read_en_len: got %0d want 3", acc_len[base]); end
    checks++; if (acc_addr[base] !== 32'h400 || acc_wr[base] !== 1'b0 || acc_bad[base]) begin errors++; $display("FAIL read_bus: got addr %h wr %b unstable %b want 400/0/0", acc_addr[base], acc_wr[base], acc_bad[base]); end
    checks++; if (n_done0 != d0 + 1 || n_done1 != d1 || n_wide != w) begin errors++; $display("FAIL read_done: got d0 %0d d1 %0d wide %0d want 1/0/0", n_done0 - d0, n_done1 - d1, n_wide - w); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata0_hold: got %h want deadbeef", rdata0); end
  endtask

  task automatic test_write();
    int t, base, d0, d1, w;
    ctl_rdata = 32'hCAFEF00D;
    base = n_acc; d0 = n_done0; d1 = n_done1; w = n_wide;
    rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'h408; wdata1 = 32'h12345678;
    t = 0;
    do begin tick(1); t++; end while (done1 !== 1'b1 && t < 50);
    checks++; if (t != 4) begin errors++; $display("FAIL write_latency: got %0d want 4", t); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL write_rdata1: got %h want 0", rdata1); end
    wr1 = 1'b0;
    tick(4);
    checks++; if (n_acc != base + 1 || acc_wr[base] !== 1'b1 || acc_len[base] != 3) begin errors++; $display("FAIL write_grant: got n %0d wr %b len %0d want 1/1/3", n_acc - base, acc_wr[base], acc_len[base]); end
    checks++; if (acc_addr[base] !== 32'h408 || acc_wdata[base] !== 32'h12345678 || acc_bad[base]) begin errors++; $display("FAIL write_bus: got %h/%h want 408/12345678", acc_addr[base], acc_wdata[base]); end
    checks++; if (n_done1 != d1 + 1 || n_done0 != d0 || n_wide != w) begin errors++; $display("FAIL write_done: got d0 %0d d1 %0d wide %0d want 0/1/0", n_done0 - d0, n_done1 - d1, n_wide - w); end
    checks++; if (rdata1 !== 32'h0 || n_both != 0) begin errors++; $display("FAIL write_rdata1_hold: got %h both %0d want 0/0", rdata1, n_both); end
  endtask

  task automatic test_contention();
    int base;
    do_reset();
    ctl_force = 1'b0; ctl_lat = 3;
    op_n[0] = 1; op_rd[0][0] = 1'b1; op_wr[0][0] = 1'b0; op_addr[0][0] = 32'h100;      op_wdata[0][0] = 32'h0;
    op_n[1] = 1; op_rd[1][0] = 1'b0; op_wr[1][0] = 1'b1; op_addr[1][0] = 32'h10000200; op_wdata[1][0] = $urandom();
    base = n_acc;
    fork agent(0); agent(1); join
    tick(4);
    checks++; if (n_acc != base + 2) begin errors++; $display("FAIL tie_grants: got %0d want 2", n_acc - base); end
    checks++; if (acc_addr[base] !== 32'h100 || acc_wr[base] !== 1'b0) begin errors++; $display("FAIL tie_first: got %h wr %b want 100/0", acc_addr[base], acc_wr[base]); end
    checks++; if (acc_addr[base+1] !== 32'h10000200 || acc_wr[base+1] !== 1'b1 || acc_wdata[base+1] !== op_wdata[1][0]) begin errors++; $display("FAIL tie_second: got %h wr %b wd %h want 10000200/1/%h", acc_addr[base+1], acc_wr[base+1], acc_wdata[base+1], op_wdata[1][0]); end
    checks++; if (acc_gap[base+1] < 2) begin errors++; $display("FAIL tie_gap: got %0d want >=2", acc_gap[base+1]); end
    checks++; if (rdata0 !== rdfn(32'h100)) begin errors++; $display("FAIL tie_rdata0: got %h want %h", rdata0, rdfn(32'h100)); end
  endtask

  task automatic test_alternate();
    int n[2];
    int exp_p[16], exp_i[16];
    int k, i0, i1, pk, ix, base, d0, d1, w, b;
    logic [31:0] a;
    do_reset();
    mdl_last = 1; mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
    ctl_force = 1'b0;
    for (int r = 0; r < 3; r++) begin
      ctl_lat = $urandom_range(2, 5);
      n[0] = (r == 0) ? 3 : $urandom_range(1, 4);
      n[1] = (r == 0) ? 3 : $urandom_range(1, 4);
      for (int p = 0; p < 2; p++) begin
        op_n[p] = n[p];
        for (int i = 0; i < n[p]; i++) begin
          a = $urandom();
          a[31:28] = 4'(p);
          a[1:0] = 2'b00;
          op_addr[p][i]  = a;
          op_wdata[p][i] = $urandom();
          op_wr[p][i]    = 1'($urandom_range(0, 1));
          op_rd[p][i]    = op_wr[p][i] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      // Round-robin: alternate while both have work, else serve whoever has.
      k = 0; i0 = 0; i1 = 0;
      while (i0 < n[0] || i1 < n[1]) begin
        if (i0 < n[0] && i1 < n[1]) pk = (mdl_last == 0) ? 1 : 0;
        else                        pk = (i0 < n[0]) ? 0 : 1;
        exp_p[k] = pk;
        exp_i[k] = (pk == 0) ? i0 : i1;
        if (pk == 0) i0++; else i1++;
        mdl_last = pk;
        k++;
      end
      base = n_acc; d0 = n_done0; d1 = n_done1; w = n_wide; b = n_both;
      fork agent(0); agent(1); join
      tick(4);
      checks++; if (n_acc != base + k) begin errors++; $display("FAIL rr_count: round %0d got %0d want %0d", r, n_acc - base, k); end
      for (int j = 0; j < k; j++) begin
        pk = exp_p[j]; ix = exp_i[j];
        checks++;
        if (acc_addr[base+j] !== op_addr[pk][ix] || acc_wr[base+j] !== op_wr[pk][ix] ||
            (op_wr[pk][ix] && acc_wdata[base+j] !== op_wdata[pk][ix]) ||
            acc_len[base+j] != int'(ctl_lat) || acc_bad[base+j] || (j > 0 && acc_gap[base+j] != 2)) begin
          errors++;
          $display("FAIL rr_access: round %0d #%0d got addr %h wr %b wd %h len %0d gap %0d want addr %h wr %b wd %h len %0d gap 2",
                   r, j, acc_addr[base+j], acc_wr[base+j], acc_wdata[base+j], acc_len[base+j], acc_gap[base+j],
                   op_addr[pk][ix], op_wr[pk][ix], op_wdata[pk][ix], ctl_lat);
        end
        if (!op_wr[pk][ix]) mdl_rd[pk] = rdfn(op_addr[pk][ix]);
      end
      checks++; if (rdata0 !== mdl_rd[0] || rdata1 !== mdl_rd[1]) begin errors++; $display("FAIL rr_rdata: round %0d got %h/%h want %h/%h", r, rdata0, rdata1, mdl_rd[0], mdl_rd[1]); end
      checks++; if (n_done0 != d0 + n[0] || n_done1 != d1 + n[1] || n_wide != w || n_both != b) begin errors++; $display("FAIL rr_done: round %0d got %0d/%0d wide %0d both %0d want %0d/%0d/0/0", r, n_done0 - d0, n_done1 - d1, n_wide - w, n_both - b, n[0], n[1]); end
    end
  endtask

  task automatic test_timeout();
    int t, base, d1, w;
    ctl_hang = 1'b1;
    base = n_acc; d1 = n_done1; w = n_wide;
    rd1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10000040;
    t = 0;
    do begin tick(1); t++; end while (done1 !== 1'b1 && t < 60);
    checks++; if (t != TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", t, TMO + 1); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err); end
    checks++; if (rdata1 !== mdl_rd[1]) begin errors++; $display("FAIL tmo_rdata1: got %h want %h", rdata1, mdl_rd[1]); end
    rd1 = 1'b0; ctl_hang = 1'b0;
    tick(4);
    checks++; if (acc_len[base] != TMO || n_done1 != d1 + 1 || n_wide != w) begin errors++; $display("FAIL tmo_grant: got len %0d done %0d wide %0d want %0d/1/0", acc_len[base], n_done1 - d1, n_wide - w, TMO); end
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h44;
    t = 0;
    do begin tick(1); t++; end while (done0 !== 1'b1 && t < 50);
    checks++; if (rdata0 !== rdfn(32'h44)) begin errors++; $display("FAIL tmo_next_rdata0: got %h want %h", rdata0, rdfn(32'h44)); end
    mdl_rd[0] = rdfn(32'h44);
    rd0 = 1'b0;
    tick(3);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    int d0;
    ctl_hang = 1'b1;
    d0 = n_done0;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h80;
    tick(3);
    checks++; if (sram_rd_en !== 1'b1 || sram_address !== 32'h80) begin errors++; $display("FAIL rstmid_busy: got en %b addr %h want 1/80", sram_rd_en, sram_address); end
    rst = 1'b1;
    tick(1);
    checks++; if ({sram_rd_en, sram_wr_en, done0, err} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {sram_rd_en, sram_wr_en, done0, err}); end
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", rdata0, rdata1); end
    rd0 = 1'b0; rst = 1'b0;
    tick(5);
    checks++; if (n_done0 != d0 || sram_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got done %0d en %b want 0/0", n_done0 - d0, sram_rd_en); end
    ctl_hang = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_alternate();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller port between two requesters: port 0 (instruction fetch) and port 1 (data memory stage).
- Sits between the pipeline/memory-stage logic and the SRAM controller. It drives that controller's wr_en/rd_en/address/writeData and consumes its readData/ready.
- Round-robin arbitration and one-access-at-a-time sequencing, with a mandatory recovery cycle between accesses so the controller's access counter reloads.
- A watchdog aborts hung accesses.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- TIMEOUT, 16, max cycles in a grant state waiting for sram_ready before abort (must be >= 2)
- TMO_W, 5, width of the watchdog counter; must hold TIMEOUT

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd0  in  1  port 0 read request, level, held until done0
- wr0  in  1  port 0 write request, level, held until done0
- addr0  in  ADDR_W  port 0 byte address, stable while request held
- wdata0  in  DATA_W  port 0 write data
- rdata0  out  DATA_W  port 0 read data, registered
- done0  out  1  port 0 completion pulse
- rd1, wr1, addr1, wdata1, rdata1, done1  same as port 0, for port 1
- err  out  1  sticky watchdog-abort flag
- sram_rd_en  out  1  to controller rd_en
- sram_wr_en  out  1  to controller wr_en
- sram_address  out  ADDR_W  to controller address
- sram_writeData  out  DATA_W  to controller writeData
- sram_readData  in  DATA_W  from controller readData
- sram_ready  in  1  from controller ready

Behaviour:
- States: IDLE, GNT0, GNT1, RECOVER. The state register and last_grant register are updated only in the clocked process.
- Reset:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - rdata0=rdata1=0, done0=done1=0, err=0, watchdog=0.
  - sram_rd_en=sram_wr_en=0.
  - Reset mid-access drops the access immediately; no done is issued for it.
- IDLE:
  - Port n is requesting when rdn|wrn.
  - Neither port requesting: stay in IDLE.
  - One port requesting: go to that port's GNT.
  - Both requesting: grant the port != last_grant.
  - Update last_grant on entry to GNT.
- GNTn:
  - Downstream outputs are combinational from state. sram_address=addrn, sram_writeData=wdatan.
  - If wrn: sram_wr_en=1, sram_rd_en=0. Otherwise sram_rd_en=rdn.
  - rdn and wrn both high on a port counts as a write (wr wins).
  - Outside GNT states all sram_* enables are 0; address and writeData are don't-care but driven 0.
  - Completion: when sram_ready=1 while in GNTn, the next state is RECOVER.
    - On that edge, if the access is a read: rdatan <= sram_readData.
    - donen <= 1 for exactly one cycle, i.e. high during the RECOVER cycle.
  - The ready sampled in the first GNT cycle counts. The controller drops ready combinationally once enabled, so ready=1 in the first cycle never occurs for a compliant controller. The arbiter must not special-case it.
- Watchdog:
  - Counter clears on entry to GNT and increments each GNT cycle.
  - If it reaches TIMEOUT-1 without sram_ready: go to RECOVER, err <= 1 (sticky until rst), donen <= 1, rdatan unchanged.
- RECOVER:
  - All enables 0 for exactly one cycle, then IDLE.
  - Requests are ignored in RECOVER.
  - Requesters drop req at the edge after seeing done, so the requests seen in IDLE are fresh.
- Latency and throughput:
  - Uncontended access: 1 cycle IDLE→GNT, plus the controller's access time, plus 1 RECOVER cycle.
  - Minimum gap between back-to-back grants: 2 cycles (RECOVER, IDLE).
- rdatan holds its value until the next completed read on that port; writes do not modify rdatan.
- Under round-robin, two continuously requesting ports alternate strictly: 0,1,0,1…

Test Plan:
- Reset, then rd0=1, addr0=0x400; controller model returns 0xDEADBEEF, ready after 3 cycles → sram_rd_en high exactly 3 cycles with sram_address=0x400; done0 pulses once; rdata0=0xDEADBEEF; done1 stays 0.
- wr1=1, addr1=0x408, wdata1=0x12345678 → sram_wr_en=1, sram_writeData=0x12345678, sram_address=0x408 during grant; done1 single pulse; rdata1 unchanged.
- rd0 and wr1 asserted in the same cycle after reset → port 0 granted first, then RECOVER, IDLE, then port 1; enables low for ≥1 cycle between the two grants.
- Both ports held requesting for 6 accesses → grant order 0,1,0,1,0,1; each done pulse is one cycle.
- Controller model never raises ready, with rd1=1 → abort after TIMEOUT cycles in GNT1; done1 pulses; err=1 and stays 1 through further accesses until rst.
- rst asserted mid-GNT0 → next cycle state IDLE, enables 0, done0 never pulses, err cleared, rdata0=0.
